seq_block_subtractor: RTL and testbench

- Multi-cycle W-bit subtractor: diff = a - b - bin, with borrow-out bout.
- Processes one B-bit block per clock, LSB block first, through a registered borrow chain.
- Area-lean counterpart to the single-cycle block-structured adder; reuses the same W/B block partitioning.
- Sits behind a valid/ready input port and a valid/ready result port in the datapath.

---
 rtl/seq_block_subtractor.sv | 107 ++++++++++
 tb/tb_seq_block_subtractor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_block_subtractor.sv
// rtl/seq_block_subtractor.sv - multi-cycle block-serial W-bit subtractor (optional SUB_OVF_EN adds ovf)
module seq_block_subtractor #(
  parameter int W = 128,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int NB = W / B;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  diff_reg;
  logic          br;
  logic          bout_reg;
  logic [IW-1:0] idx;
  logic [B-1:0]  a_blk;
  logic [B-1:0]  b_blk;
  logic [B:0]    blk;
`ifdef SUB_OVF_EN
  logic          ovf_reg;
`endif

  // Current block slice and its subtraction; the MSB of blk is the block borrow-out
  always_comb begin
    a_blk = a_reg[idx*B +: B];
    b_blk = b_reg[idx*B +: B];
    blk   = {1'b0, a_blk} - {1'b0, b_blk} - {{B{1'b0}}, br};
  end

  // Control FSM, operand capture and block-serial borrow chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      br       <= 1'b0;
      bout_reg <= 1'b0;
      idx      <= '0;
`ifdef SUB_OVF_EN
      ovf_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            br    <= bin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff_reg[idx*B +: B] <= blk[B-1:0];
          br <= blk[B];
          if (idx == LAST) begin
            bout_reg <= blk[B];
`ifdef SUB_OVF_EN
            // Top bit of the last block is the sign of the result
            ovf_reg  <= (a_reg[W-1] != b_reg[W-1]) && (blk[B-1] != a_reg[W-1]);
`endif
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_reg;
  assign bout      = bout_reg;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_seq_block_subtractor.sv
// tb/tb_seq_block_subtractor.sv - self-checking bench for seq_block_subtractor (honours SUB_OVF_EN)
module tb_seq_block_subtractor;

  localparam int W  = 128;
  localparam int B  = 4;
  localparam int NB = W / B;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  seq_block_subtractor #(.W(W), .B(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: full-precision unsigned and signed arithmetic
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ediff, output logic ebout, output logic eovf);
    logic [W:0]   u;
    logic [W+1:0] s;
    u = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    ediff = u[W-1:0];
    ebout = u[W];
    s = {{2{ma[W-1]}}, ma} - {{2{mb[W-1]}}, mb} - (W+2)'(mbin);
    eovf = !((s[W+1] == s[W]) && (s[W] == s[W-1]));
  endtask

  // One operation from accept to release; hold > 0 applies backpressure in DONE
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input int hold);
    logic [W-1:0] ediff;
    logic ebout, eovf;
    int n;
    model(ta, tb_, tbin, ediff, ebout, eovf);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, (W+1)'(in_ready), (W+1)'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd128(); b = rnd128(); bin = $urandom_range(0, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, (W+1)'(n), (W+1)'(NB));
    chk({tag, ".diff"}, {1'b0, diff}, {1'b0, ediff});
    chk({tag, ".bout"}, (W+1)'(bout), (W+1)'(ebout));
`ifdef SUB_OVF_EN
    chk({tag, ".ovf"}, (W+1)'(ovf), (W+1)'(eovf));
`endif
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; a = rnd128(); b = rnd128();
        @(posedge clk); #1;
        chk({tag, ".hold_valid"}, (W+1)'(out_valid), (W+1)'(1));
        chk({tag, ".hold_in_ready"}, (W+1)'(in_ready), (W+1)'(0));
        chk({tag, ".hold_diff"}, {1'b0, diff}, {1'b0, ediff});
        chk({tag, ".hold_bout"}, (W+1)'(bout), (W+1)'(ebout));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, (W+1)'(out_valid), (W+1)'(0));
    chk({tag, ".in_ready_back"}, (W+1)'(in_ready), (W+1)'(1));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] dead;
    logic [W-1:0] maxpos;
    ones   = '1;
    dead   = {4{32'hDEAD_BEEF}};
    maxpos = {1'b0, {(W-1){1'b1}}};

    // Reset state
    #12;
    chk("rst.in_ready", (W+1)'(in_ready), (W+1)'(1));
    chk("rst.out_valid", (W+1)'(out_valid), (W+1)'(0));
    chk("rst.diff", {1'b0, diff}, '0);
    chk("rst.bout", (W+1)'(bout), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op("basic", W'(5), W'(3), 1'b0, 0);
    run_op("underflow", '0, W'(1), 1'b0, 0);
    run_op("equal_bin", dead, dead, 1'b1, 0);
    run_op("cross_block", W'(1) << 64, W'(1), 1'b0, 0);
    run_op("all_ones", ones, ones, 1'b0, 0);
    run_op("ovf_pos", maxpos, ones, 1'b0, 0);
    run_op("ovf_none", W'(3), W'(1), 1'b0, 0);

    // Backpressure, then a follow-up op
    run_op("backpressure", rnd128(), rnd128(), 1'b0, 10);
    run_op("after_bp", W'(100), W'(42), 1'b1, 0);

    // Reset in the middle of RUN
    a = rnd128(); b = rnd128(); bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.out_valid", (W+1)'(out_valid), '0);
    chk("abort.diff", {1'b0, diff}, '0);
    chk("abort.bout", (W+1)'(bout), '0);
    chk("abort.in_ready", (W+1)'(in_ready), (W+1)'(1));
`ifdef SUB_OVF_EN
    chk("abort.ovf", (W+1)'(ovf), '0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_abort.in_ready", (W+1)'(in_ready), (W+1)'(1));
    run_op("post_abort", W'(7), W'(9), 1'b0, 0);

    // Random operations
    for (int i = 0; i < 12; i++) begin
      run_op("random", rnd128(), rnd128(), 1'($urandom_range(0, 1)), (i % 4 == 3) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
